// File: rtl/register_file.sv
// register_file: architectural register file with per-register rename tags.
// Each register holds a committed value, a busy bit and the ROB slot that will
// produce its next value. Dispatch reads either a ready value or that ROB slot.
// Optional feature: define RF_BYPASS_EN to forward a same-cycle commit to the
// read ports (value always, busy cleared only when the commit owns the rename).
module register_file #(
    parameter int ROB_IDX_W = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear_in,
    input  logic                 issue_req,
    input  logic [4:0]           issue_rd,
    input  logic [ROB_IDX_W-1:0] issue_rob_id,
    input  logic [4:0]           commit_rd,
    input  logic [31:0]          commit_val,
    input  logic [ROB_IDX_W-1:0] commit_rob_id,
    input  logic [4:0]           rs1_addr,
    input  logic [4:0]           rs2_addr,
    output logic [31:0]          rs1_val,
    output logic [31:0]          rs2_val,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic [ROB_IDX_W-1:0] rs1_rob_id,
    output logic [ROB_IDX_W-1:0] rs2_rob_id
);

    logic [31:0]          val_q [32];
    logic [31:0]          val_d [32];
    logic [31:0]          busy_q;
    logic [31:0]          busy_d;
    logic [ROB_IDX_W-1:0] tag_q [32];
    logic [ROB_IDX_W-1:0] tag_d [32];

    logic [4:0]           rd_addr [2];
    logic [31:0]          rd_val  [2];
    logic                 rd_busy [2];
    logic [ROB_IDX_W-1:0] rd_tag  [2];

    logic commit_en;
    logic issue_en;

    assign commit_en = rdy_in && (commit_rd != 5'd0);
    assign issue_en  = rdy_in && !clear_in && issue_req && (issue_rd != 5'd0);

    // Next state: commit writes the value and retires the rename only if it still owns it; clear drops all renames; issue overrides commit.
    always_comb begin
        val_d  = val_q;
        busy_d = busy_q;
        tag_d  = tag_q;
        if (commit_en) begin
            val_d[commit_rd] = commit_val;
            if (tag_q[commit_rd] == commit_rob_id) begin
                busy_d[commit_rd] = 1'b0;
            end
        end
        if (rdy_in && clear_in) begin
            busy_d = '0;
        end else if (issue_en) begin
            busy_d[issue_rd] = 1'b1;
            tag_d[issue_rd]  = issue_rob_id;
        end
    end

    // State registers with synchronous reset; x0 is never written so it stays zero.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q <= '0;
            for (int i = 0; i < 32; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            for (int i = 0; i < 32; i++) begin
                val_q[i] <= val_d[i];
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign rd_addr[0] = rs1_addr;
    assign rd_addr[1] = rs2_addr;

    // Combinational operand reads from current state, with optional commit forwarding and x0 forced to zero.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_val[p]  = val_q[rd_addr[p]];
            rd_busy[p] = busy_q[rd_addr[p]];
            rd_tag[p]  = tag_q[rd_addr[p]];
`ifdef RF_BYPASS_EN
            if (commit_en && (rd_addr[p] == commit_rd)) begin
                rd_val[p] = commit_val;
                if (busy_q[commit_rd] && (tag_q[commit_rd] == commit_rob_id)) begin
                    rd_busy[p] = 1'b0;
                end
            end
`endif
            if (rd_addr[p] == 5'd0) begin
                rd_val[p]  = '0;
                rd_busy[p] = 1'b0;
                rd_tag[p]  = '0;
            end
        end
    end

    assign rs1_val    = rd_val[0];
    assign rs1_busy   = rd_busy[0];
    assign rs1_rob_id = rd_tag[0];
    assign rs2_val    = rd_val[1];
    assign rs2_busy   = rd_busy[1];
    assign rs2_rob_id = rd_tag[1];

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: scoreboard bench for register_file. Expected read results
// are queued as each read is set up and compared once the outputs settle.
module tb_register_file;

    localparam int W = 4;

    logic          clk_in;
    logic          rst_in;
    logic          rdy_in;
    logic          clear_in;
    logic          issue_req;
    logic [4:0]    issue_rd;
    logic [W-1:0]  issue_rob_id;
    logic [4:0]    commit_rd;
    logic [31:0]   commit_val;
    logic [W-1:0]  commit_rob_id;
    logic [4:0]    rs1_addr;
    logic [4:0]    rs2_addr;
    logic [31:0]   rs1_val;
    logic [31:0]   rs2_val;
    logic          rs1_busy;
    logic          rs2_busy;
    logic [W-1:0]  rs1_rob_id;
    logic [W-1:0]  rs2_rob_id;

    int checkCount;
    int errorCount;

    logic [37:0] expQ[$];
    string       tagQ[$];
    logic [31:0] model [32];

    register_file #(.ROB_IDX_W(W)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .issue_req(issue_req), .issue_rd(issue_rd), .issue_rob_id(issue_rob_id),
        .commit_rd(commit_rd), .commit_val(commit_val), .commit_rob_id(commit_rob_id),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_val(rs1_val), .rs2_val(rs2_val),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rs1_rob_id(rs1_rob_id), .rs2_rob_id(rs2_rob_id)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Single comparison point: counts and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [36:0] observed, input logic [36:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got busy/rob/val=%h want %h", tag, observed, expected);
        end
    endtask

    // Drives inputs at the falling edge so they are stable for the next rising edge.
    task automatic applyStimulus(input logic iss, input logic [4:0] ird, input logic [W-1:0] irob,
                                 input logic [4:0] crd, input logic [31:0] cval, input logic [W-1:0] crob,
                                 input logic clr, input logic rdy, input logic rst);
        @(negedge clk_in);
        issue_req     = iss;
        issue_rd      = ird;
        issue_rob_id  = irob;
        commit_rd     = crd;
        commit_val    = cval;
        commit_rob_id = crob;
        clear_in      = clr;
        rdy_in        = rdy;
        rst_in        = rst;
    endtask

    // Lets the rising edge happen, then returns inputs to idle.
    task automatic clockEdge();
        @(posedge clk_in);
        #1;
        issue_req = 1'b0;
        issue_rd  = '0;
        commit_rd = '0;
        clear_in  = 1'b0;
        rdy_in    = 1'b1;
        rst_in    = 1'b0;
    endtask

    task automatic doCycle(input logic iss, input logic [4:0] ird, input logic [W-1:0] irob,
                           input logic [4:0] crd, input logic [31:0] cval, input logic [W-1:0] crob,
                           input logic clr, input logic rdy, input logic rst);
        applyStimulus(iss, ird, irob, crd, cval, crob, clr, rdy, rst);
        clockEdge();
    endtask

    // Points a read port at a register and queues the expected {busy, rob, val}.
    task automatic expectRead(input string tag, input logic port, input logic [4:0] addr,
                              input logic busy, input logic [W-1:0] rob, input logic [31:0] val);
        if (port) rs2_addr = addr;
        else      rs1_addr = addr;
        expQ.push_back({port, busy, rob, val});
        tagQ.push_back(tag);
    endtask

    // Lets reads settle, then pops every queued expectation and compares.
    task automatic drainReads();
        logic [37:0] e;
        logic [36:0] obs;
        string       t;
        #1;
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            t = tagQ.pop_front();
            obs = e[37] ? {rs2_busy, rs2_rob_id, rs2_val} : {rs1_busy, rs1_rob_id, rs1_val};
            checkOutput(t, obs, e[36:0]);
        end
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        rs1_addr = '0;
        rs2_addr = '0;
        issue_rob_id = '0;
        commit_val = '0;
        commit_rob_id = '0;
        clockEdge();

        // reset
        doCycle(0, 0, 0, 0, 0, 0, 0, 1, 1);
        doCycle(0, 0, 0, 0, 0, 0, 0, 1, 1);
        expectRead("rst_x5", 0, 5, 0, 0, 0);
        expectRead("rst_x0", 1, 0, 0, 0, 0);
        drainReads();

        // x0 ignores writes
        doCycle(0, 0, 0, 0, 32'hDEAD, 0, 0, 1, 0);
        expectRead("x0_write", 0, 0, 0, 0, 0);
        drainReads();

        // basic rename then commit
        doCycle(1, 3, 2, 0, 0, 0, 0, 1, 0);
        expectRead("issue_x3", 0, 3, 1, 2, 0);
        drainReads();
        doCycle(0, 0, 0, 3, 32'h1234, 2, 0, 1, 0);
        expectRead("commit_x3", 0, 3, 0, 2, 32'h1234);
        drainReads();

        // stale commit keeps the younger rename
        doCycle(1, 7, 1, 0, 0, 0, 0, 1, 0);
        doCycle(1, 7, 4, 0, 0, 0, 0, 1, 0);
        doCycle(0, 0, 0, 7, 32'd9, 1, 0, 1, 0);
        expectRead("stale_x7", 1, 7, 1, 4, 32'd9);
        drainReads();
        doCycle(0, 0, 0, 7, 32'd11, 4, 0, 1, 0);
        expectRead("final_x7", 1, 7, 0, 4, 32'd11);
        drainReads();

        // same-cycle issue and commit on x4
        doCycle(1, 4, 6, 0, 0, 0, 0, 1, 0);
        doCycle(1, 4, 5, 4, 32'h55, 6, 0, 1, 0);
        expectRead("iss_cmt_x4", 0, 4, 1, 5, 32'h55);
        drainReads();

        // clear with a final commit; issue in the same cycle is ignored
        doCycle(1, 2, 1, 0, 0, 0, 0, 1, 0);
        doCycle(1, 6, 7, 0, 0, 0, 0, 1, 0);
        doCycle(1, 9, 3, 2, 32'hAA, 9, 1, 1, 0);
        expectRead("clr_x2", 0, 2, 0, 1, 32'hAA);
        expectRead("clr_x6", 1, 6, 0, 7, 0);
        drainReads();
        expectRead("clr_x9", 0, 9, 0, 0, 0);
        expectRead("clr_x4", 1, 4, 0, 5, 32'h55);
        drainReads();

        // rdy low holds state
        doCycle(1, 10, 2, 11, 32'd5, 0, 0, 0, 0);
        expectRead("hold_x10", 0, 10, 0, 0, 0);
        expectRead("hold_x11", 1, 11, 0, 0, 0);
        drainReads();

        // commit-to-read in the same cycle
        doCycle(1, 8, 3, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 8, 32'h77, 3, 0, 1, 0);
`ifdef RF_BYPASS_EN
        expectRead("same_cyc_x8", 1, 8, 0, 3, 32'h77);
`else
        expectRead("same_cyc_x8", 1, 8, 1, 3, 0);
`endif
        drainReads();
        clockEdge();
        expectRead("after_x8", 1, 8, 0, 3, 32'h77);
        drainReads();

        // reset mid-sequence
        doCycle(1, 12, 5, 0, 0, 0, 0, 1, 0);
        doCycle(0, 0, 0, 0, 0, 0, 0, 1, 1);
        expectRead("rst2_x12", 0, 12, 0, 0, 0);
        expectRead("rst2_x3", 1, 3, 0, 0, 0);
        drainReads();

        // fill every register with random values, then read all back
        for (int r = 1; r < 32; r++) begin
            model[r] = $urandom;
            doCycle(0, 0, 0, r[4:0], model[r], 0, 0, 1, 0);
        end
        for (int r = 1; r < 32; r++) begin
            expectRead($sformatf("fill_x%0d", r), r[0], r[4:0], 0, 0, model[r]);
            drainReads();
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
